// File: rtl/weight_loader.sv
// Weight loader: collects a stream of data_size-bit weight words into rows of
// `size` words. Each complete row goes out on a one-cycle write strobe to the
// weight storage. One load covers size*layer_size rows, in layer-major order.
module weight_loader #(
  parameter int data_size  = 16,
  parameter int size       = 3,
  parameter int layer_size = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [data_size-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [31:0]                 write_layer_index,
  output logic [31:0]                 write_row_index,
  output logic [data_size*size-1:0]   write_data,
  output logic                        is_write,
  output logic                        busy,
  output logic                        done
);

  localparam int          row_w      = data_size * size;
  localparam logic [31:0] last_word  = 32'(size - 1);
  localparam logic [31:0] last_row   = 32'(size - 1);
  localparam logic [31:0] last_layer = 32'(layer_size - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e             state_q;
  logic [31:0]        word_cnt_q;
  logic [31:0]        row_cnt_q;
  logic [31:0]        layer_cnt_q;
  logic [row_w-1:0]   row_q;
  logic [row_w-1:0]   row_d;
  logic [row_w-1:0]   write_data_q;
  logic [31:0]        write_row_index_q;
  logic [31:0]        write_layer_index_q;
  logic               in_ready_q;
  logic               is_write_q;
  logic               busy_q;
  logic               done_q;
  logic               accept;

  // A word is consumed only on a valid/ready handshake. The ready register
  // is high only in COLLECT.
  assign accept = in_valid && in_ready_q;

  // Place an accepted word into its column slot. Word 0 lands in the MSB slot.
  always_comb begin
    // NOTE: default the whole vector first so every path assigns it and no latch is inferred.
    row_d = row_q;
    for (int c = 0; c < size; c++) begin
      if (accept && (word_cnt_q == 32'(c))) begin
        row_d[(size - c) * data_size - 1 -: data_size] = in_data;
      end
    end
  end

  // Load sequencer: state, counters, row buffer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the row buffer is only `size` words of flops, not a RAM. Resetting it keeps
    // write_data at a defined zero after a reset.
    if (!rst_n) begin
      state_q             <= ST_IDLE;
      word_cnt_q          <= '0;
      row_cnt_q           <= '0;
      layer_cnt_q         <= '0;
      row_q               <= '0;
      write_data_q        <= '0;
      write_row_index_q   <= '0;
      write_layer_index_q <= '0;
      in_ready_q          <= 1'b0;
      is_write_q          <= 1'b0;
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so that every register here sees the pre-edge values.
      is_write_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            word_cnt_q  <= '0;
            row_cnt_q   <= '0;
            layer_cnt_q <= '0;
            state_q     <= ST_COLLECT;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            row_q <= row_d;
            if (word_cnt_q == last_word) begin
              // The row is complete. Present it together with its indices for
              // exactly the one WRITE cycle.
              word_cnt_q          <= '0;
              state_q             <= ST_WRITE;
              in_ready_q          <= 1'b0;
              is_write_q          <= 1'b1;
              write_data_q        <= row_d;
              write_row_index_q   <= row_cnt_q;
              write_layer_index_q <= layer_cnt_q;
            end else begin
              word_cnt_q <= word_cnt_q + 32'd1;
            end
          end
        end
        ST_WRITE: begin
          if (row_cnt_q != last_row) begin
            row_cnt_q  <= row_cnt_q + 32'd1;
            state_q    <= ST_COLLECT;
            in_ready_q <= 1'b1;
          end else if (layer_cnt_q != last_layer) begin
            row_cnt_q   <= '0;
            layer_cnt_q <= layer_cnt_q + 32'd1;
            state_q     <= ST_COLLECT;
            in_ready_q  <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign is_write          = is_write_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign write_data        = write_data_q;
  assign write_row_index   = write_row_index_q;
  assign write_layer_index = write_layer_index_q;

endmodule
